// File: rtl/edge_pulse_meter.sv
// Measures high time and period of a signal from its edge pulses.
// Ports: clk, rst, en, pos/neg_edge_in; m_valid/m_ready result port
// carrying m_high, m_period, m_sat; overrun and proto_err pulses.
module edge_pulse_meter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pos_edge_in,
  input  logic             neg_edge_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_high,
  output logic [CNT_W-1:0] m_period,
  output logic             m_sat,
  output logic             overrun,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_lat;
  logic             sat;

  logic             both;
  logic             done;
  logic             xfer;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_hit;

  assign both    = pos_edge_in & neg_edge_in;
  assign done    = en && !both &&
                   (state == LOW) && pos_edge_in;
  assign xfer    = m_valid && m_ready;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt
                                    : cnt + CNT_ONE;
  // sat marks the cycle the counter reaches its top
  assign cnt_hit = (cnt_inc == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      high_lat  <= '0;
      sat       <= 1'b0;
      m_valid   <= 1'b0;
      m_high    <= '0;
      m_period  <= '0;
      m_sat     <= 1'b0;
      overrun   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      proto_err <= both;
      overrun   <= 1'b0;

      if (!en || both) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (pos_edge_in) begin
              state <= HIGH;
              cnt   <= CNT_ONE;
              sat   <= 1'b0;
            end
          end
          HIGH: begin
            if (pos_edge_in) begin
              // neg was missed: restart from this rise
              cnt <= CNT_ONE;
              sat <= 1'b0;
            end else begin
              if (neg_edge_in) begin
                high_lat <= cnt;
                state    <= LOW;
              end
              cnt <= cnt_inc;
              if (cnt_hit) sat <= 1'b1;
            end
          end
          LOW: begin
            if (pos_edge_in) begin
              cnt   <= CNT_ONE;
              sat   <= 1'b0;
              state <= HIGH;
            end else begin
              cnt <= cnt_inc;
              if (cnt_hit) sat <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // one-entry result buffer
      if (done) begin
        if (!m_valid || m_ready) begin
          m_valid  <= 1'b1;
          m_high   <= high_lat;
          m_period <= cnt;
          m_sat    <= sat;
        end else begin
          overrun <= 1'b1;
        end
      end else if (xfer) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_edge_pulse_meter.sv
// Bench for edge_pulse_meter: vector tables, corner sequences
// and random traffic against a timestamp-based reference model.
module tb_edge_pulse_meter;

  localparam int W    = 4;
  localparam int MAXV = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         pos;
  logic         neg;
  logic         rdy;
  logic         vld;
  logic [W-1:0] hi;
  logic [W-1:0] per;
  logic         sat;
  logic         ovr;
  logic         perr;

  always #5 clk = ~clk;

  edge_pulse_meter #(.CNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pos_edge_in(pos),
    .neg_edge_in(neg),
    .m_valid    (vld),
    .m_ready    (rdy),
    .m_high     (hi),
    .m_period   (per),
    .m_sat      (sat),
    .overrun    (ovr),
    .proto_err  (perr)
  );

  typedef struct packed {
    logic         v;
    logic [W-1:0] h;
    logic [W-1:0] p;
    logic         s;
    logic         o;
    logic         e;
  } out_t;

  typedef struct {
    logic en;
    logic pos;
    logic neg;
    logic rdy;
    out_t exp;
  } vec_t;

  out_t got;
  assign got = {vld, hi, per, sat, ovr, perr};

  int total = 0;
  int bad   = 0;

  // reference model: rise/fall timestamps
  bit   m_act;
  bit   m_gotneg;
  int   m_tpos;
  int   m_tneg;
  int   m_t;
  out_t mdl;

  function automatic int capv(input int x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  function automatic out_t mk(input logic v, input int h,
                              input int p, input logic s,
                              input logic o, input logic e);
    out_t r;
    r.v = v;
    r.h = W'(h);
    r.p = W'(p);
    r.s = s;
    r.o = o;
    r.e = e;
    return r;
  endfunction

  task automatic model_reset();
    m_act    = 0;
    m_gotneg = 0;
    m_tpos   = 0;
    m_tneg   = 0;
    m_t      = 0;
    mdl      = '0;
  endtask

  task automatic model_step(input logic e, input logic p,
                            input logic n, input logic r);
    bit done;
    bit xf;
    int hh;
    int pp;
    done  = 0;
    hh    = 0;
    pp    = 0;
    xf    = mdl.v && r;
    mdl.e = p && n;
    mdl.o = 1'b0;
    if ((p && n) || !e) begin
      m_act = 0;
    end else if (p) begin
      if (m_act && m_gotneg) begin
        done = 1;
        hh   = m_tneg - m_tpos;
        pp   = m_t - m_tpos;
      end
      m_act    = 1;
      m_gotneg = 0;
      m_tpos   = m_t;
    end else if (n && m_act && !m_gotneg) begin
      m_gotneg = 1;
      m_tneg   = m_t;
    end
    if (done) begin
      if (!mdl.v || r) begin
        mdl.v = 1'b1;
        mdl.h = W'(capv(hh));
        mdl.p = W'(capv(pp));
        mdl.s = (pp >= MAXV);
      end else begin
        mdl.o = 1'b1;
      end
    end else if (xf) begin
      mdl.v = 1'b0;
    end
    m_t++;
  endtask

  task automatic apply(input logic e, input logic p,
                       input logic n, input logic r);
    en  = e;
    pos = p;
    neg = n;
    rdy = r;
    @(posedge clk);
    #1;
    model_step(e, p, n, r);
  endtask

  task automatic check(input string nm, input out_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h",
               nm, $time, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    pos = 1'b0;
    neg = 1'b0;
    rdy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  vec_t tab[2][24];

  initial begin
    // table: s=0 free-running consumer, s=1 backpressure
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 24; i++) begin
        logic ev;
        logic eo;
        ev = (s == 0) ? (i == 10 || i == 18)
                      : (i >= 10 && i < 22);
        eo = (s == 1) && (i == 18);
        tab[s][i].en  = 1'b1;
        tab[s][i].pos = (i == 2 || i == 10 || i == 18);
        tab[s][i].neg = (i == 5 || i == 13);
        tab[s][i].rdy = (s == 0) ? 1'b1 : (i >= 22);
        tab[s][i].exp = mk(ev, (i >= 10) ? 3 : 0,
                           (i >= 10) ? 8 : 0, 1'b0,
                           eo, 1'b0);
      end
    end

    do_reset();
    check("reset", '0);

    for (int s = 0; s < 2; s++) begin
      do_reset();
      for (int i = 0; i < 24; i++) begin
        apply(tab[s][i].en, tab[s][i].pos,
              tab[s][i].neg, tab[s][i].rdy);
        check(s == 0 ? "steady" : "backpr", tab[s][i].exp);
      end
    end

    // saturation then a normal period
    do_reset();
    for (int i = 0; i < 45; i++) begin
      apply(1'b1, i == 0 || i == 30 || i == 40,
            i == 20 || i == 35, 1'b1);
      check("sat_mdl", mdl);
      if (i == 30) check("sat_res", mk(1, 15, 15, 1, 0, 0));
      if (i == 40) check("sat_next", mk(1, 5, 10, 0, 0, 0));
    end

    // both pulses together abort the measurement
    do_reset();
    for (int i = 0; i < 18; i++) begin
      apply(1'b1, i == 2 || i == 6 || i == 14,
            i == 6 || i == 9, 1'b1);
      check("proto_mdl", mdl);
      if (i == 6) check("proto_pulse", mk(0, 0, 0, 0, 0, 1));
      if (i == 14) check("proto_nores", '0);
    end

    // missed fall restarts at the second rise
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, i == 2 || i == 6 || i == 14,
            i == 9, 1'b1);
      check("dblpos_mdl", mdl);
      if (i == 14) check("dblpos_res", mk(1, 3, 8, 0, 0, 0));
    end

    // enable dropped mid-measurement
    do_reset();
    for (int i = 0; i < 22; i++) begin
      apply(!(i == 7 || i == 8),
            i == 2 || i == 12 || i == 20,
            i == 5 || i == 15, 1'b1);
      check("en_mdl", mdl);
      if (i == 12) check("en_nores", '0);
      if (i == 20) check("en_res", mk(1, 3, 8, 0, 0, 0));
    end

    // completion on the same edge as a transfer
    do_reset();
    for (int i = 0; i < 14; i++) begin
      apply(1'b1, i == 0 || i == 5 || i == 12,
            i == 2 || i == 8, i >= 12);
      check("b2b_mdl", mdl);
      if (i == 5) check("b2b_first", mk(1, 2, 5, 0, 0, 0));
      if (i == 12) check("b2b_second", mk(1, 3, 7, 0, 0, 0));
    end

    // asynchronous reset while a result is held
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, i == 0 || i == 5, i == 2, 1'b0);
    end
    check("pre_arst", mk(1, 2, 5, 0, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 99) < 97,
            $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 70);
      check("rand", mdl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
